// File: rtl/rbm_ctrl_pkg.sv
// rbm_ctrl_pkg: sequencer state encoding and default sizing of the 9-VN/9-HN RBM test architecture
package rbm_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_ARM, S_START, S_RUN, S_READ} state_t;
  localparam int DEF_NUM_CORES  = 9;
  localparam int DEF_ROW_W      = 27;
  localparam int DEF_IDX_W      = 4;
  localparam int DEF_V_W        = 9;
  localparam int DEF_H_W        = 9;
  localparam int DEF_GAP_CYCLES = 4;
  localparam int DEF_RUN_CYCLES = 64;
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/rbm_run_sequencer_if.sv
// rbm_run_sequencer_if: host start/weight/result streams plus architecture control lines; slave=sequencer, master=host+arch
interface rbm_run_sequencer_if import rbm_ctrl_pkg::*; #(
  parameter int ROW_W = DEF_ROW_W,
  parameter int IDX_W = DEF_IDX_W,
  parameter int V_W   = DEF_V_W,
  parameter int H_W   = DEF_H_W
);
  logic             en, cfg_start, cfg_skip_w;
  logic [V_W-1:0]   cfg_v;
  logic             w_valid, w_ready;
  logic [ROW_W-1:0] w_data, arch_init_weight;
  logic [IDX_W-1:0] arch_init_weight_index, arch_out_index, res_index;
  logic             arch_init_w_en, arch_begin_operation;
  logic [V_W-1:0]   arch_init_v;
  logic [H_W-1:0]   arch_infer_h, res_data;
  logic             res_valid, res_ready, busy, done;
  modport slave (
    input  en, cfg_start, cfg_skip_w, cfg_v, w_valid, w_data, arch_infer_h, res_ready,
    output w_ready, arch_init_weight, arch_init_weight_index, arch_init_w_en, arch_init_v,
           arch_begin_operation, arch_out_index, res_valid, res_index, res_data, busy, done
  );
  modport master (
    output en, cfg_start, cfg_skip_w, cfg_v, w_valid, w_data, arch_infer_h, res_ready,
    input  w_ready, arch_init_weight, arch_init_weight_index, arch_init_w_en, arch_init_v,
           arch_begin_operation, arch_out_index, res_valid, res_index, res_data, busy, done
  );
endinterface

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down counter that stops at zero; en_i gates all updates, zero_o flags count==0
module seq_down_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (en_i) cnt_q <= load_i ? val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/rbm_run_sequencer.sv
// rbm_run_sequencer: drives weight init, visible load, begin pulse, run wait and per-core readout of the RBM architecture; ports clk, rst, bus (slave)
module rbm_run_sequencer import rbm_ctrl_pkg::*; #(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int ROW_W      = DEF_ROW_W,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int V_W        = DEF_V_W,
  parameter int H_W        = DEF_H_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int RUN_CYCLES = DEF_RUN_CYCLES
) (
  input logic               clk,
  input logic               rst,
  rbm_run_sequencer_if.slave bus
);
  localparam int CW = cnt_w(GAP_CYCLES, RUN_CYCLES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CORES - 1);
  if (NUM_CORES > 2**IDX_W || NUM_CORES < 1 || GAP_CYCLES < 1 || RUN_CYCLES < 1) begin : g_bad_cfg
    $error("rbm_run_sequencer: NUM_CORES must fit IDX_W, GAP_CYCLES and RUN_CYCLES must be >= 1");
  end
  state_t           state_q;
  logic [IDX_W-1:0] row_q, widx_q, oidx_q, ridx_q;
  logic [ROW_W-1:0] wdat_q;
  logic [V_W-1:0]   v_q;
  logic [H_W-1:0]   rdat_q;
  logic             w_ready_q, w_en_q, begin_q, done_q, res_valid_q, busy_q;
  logic             gap_zero, run_zero;
  // counters reload in every state but their own, so they enter ARM/RUN already primed
  seq_down_counter #(.W(CW)) u_gap (
    .clk(clk), .rst(rst), .en_i(bus.en), .load_i(state_q != S_ARM),
    .val_i(CW'(GAP_CYCLES - 1)), .dec_i(1'b1), .zero_o(gap_zero)
  );
  seq_down_counter #(.W(CW)) u_run (
    .clk(clk), .rst(rst), .en_i(bus.en), .load_i(state_q != S_RUN),
    .val_i(CW'(RUN_CYCLES)), .dec_i(1'b1), .zero_o(run_zero)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      widx_q      <= '0;
      oidx_q      <= '0;
      ridx_q      <= '0;
      wdat_q      <= '0;
      v_q         <= '0;
      rdat_q      <= '0;
      w_ready_q   <= 1'b0;
      w_en_q      <= 1'b0;
      begin_q     <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.en) begin
      w_en_q  <= 1'b0;
      begin_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.cfg_start) begin
          v_q       <= bus.cfg_v;
          row_q     <= '0;
          busy_q    <= 1'b1;
          w_ready_q <= !bus.cfg_skip_w;
          state_q   <= bus.cfg_skip_w ? S_ARM : S_LOAD_W;
        end
        S_LOAD_W: if (bus.w_valid && w_ready_q) begin
          wdat_q    <= bus.w_data;
          widx_q    <= row_q;
          w_en_q    <= 1'b1;
          row_q     <= row_q == LAST ? row_q : row_q + 1'b1;
          w_ready_q <= row_q != LAST;
          state_q   <= row_q == LAST ? S_ARM : S_LOAD_W;
        end
        S_ARM: state_q <= gap_zero ? S_START : S_ARM;
        S_START: begin
          begin_q <= 1'b1;
          state_q <= S_RUN;
        end
        S_RUN: if (run_zero) begin
          oidx_q  <= '0;
          state_q <= S_READ;
        end
        // capture one cycle after arch_out_index settles; drop valid on handshake to re-settle
        S_READ: if (!res_valid_q) begin
          res_valid_q <= 1'b1;
          rdat_q      <= bus.arch_infer_h;
          ridx_q      <= oidx_q;
        end else if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          oidx_q      <= oidx_q == LAST ? '0 : oidx_q + 1'b1;
          done_q      <= oidx_q == LAST;
          busy_q      <= oidx_q != LAST;
          state_q     <= oidx_q == LAST ? S_IDLE : S_READ;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  // pulses and w_ready are masked while frozen; pending pulses appear once en returns
  assign bus.w_ready                = w_ready_q & bus.en;
  assign bus.arch_init_w_en         = w_en_q & bus.en;
  assign bus.arch_begin_operation   = begin_q & bus.en;
  assign bus.done                   = done_q & bus.en;
  assign bus.arch_init_weight       = wdat_q;
  assign bus.arch_init_weight_index = widx_q;
  assign bus.arch_init_v            = v_q;
  assign bus.arch_out_index         = oidx_q;
  assign bus.res_valid              = res_valid_q;
  assign bus.res_index              = ridx_q;
  assign bus.res_data               = rdat_q;
  assign bus.busy                   = busy_q;
endmodule

// File: tb/tb_rbm_run_sequencer.sv
// tb_rbm_run_sequencer: randomized self-checking bench with an event-level reference model of the RBM run sequencer
module tb_rbm_run_sequencer;
  import rbm_ctrl_pkg::*;
  localparam int N = DEF_NUM_CORES;
  localparam int G = DEF_GAP_CYCLES;
  localparam int R = DEF_RUN_CYCLES;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  rbm_run_sequencer_if ifc ();
  rbm_run_sequencer dut (.clk(clk), .rst(rst), .bus(ifc));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [8:0] htab [16];
  assign ifc.arch_infer_h = htab[ifc.arch_out_index];
  logic [30:0] wq [$];
  int          wcyc [$];
  logic [12:0] rq [$];
  int          hcyc [$];
  int begin_cnt, done_cnt, begin_cyc, first_valid, viol;
  logic        prev_valid = 1'b0, prev_hs = 1'b0;
  logic [12:0] prev_res = '0;
  logic [3:0]  prev_widx = '0;
  always @(negedge clk) begin
    if (ifc.arch_init_w_en) begin
      wq.push_back({ifc.arch_init_weight_index, ifc.arch_init_weight});
      wcyc.push_back(cyc);
    end
    if (ifc.arch_begin_operation) begin
      begin_cnt++;
      begin_cyc = cyc;
    end
    if (ifc.res_valid && first_valid < 0) first_valid = cyc;
    if (ifc.res_valid && ifc.res_ready && ifc.en) begin
      rq.push_back({ifc.res_index, ifc.res_data});
      hcyc.push_back(cyc);
    end
    if (ifc.done) done_cnt++;
    if (!rst) begin
      if (!ifc.en && (ifc.w_ready || ifc.arch_init_w_en || ifc.arch_begin_operation || ifc.done)) viol++;
      if (ifc.en && !ifc.arch_init_w_en && ifc.arch_init_weight_index != prev_widx) viol++;
      if (ifc.res_valid && prev_valid && !prev_hs && {ifc.res_index, ifc.res_data} != prev_res) viol++;
      if (ifc.res_valid && ifc.arch_out_index != ifc.res_index) viol++;
    end
    prev_widx  = ifc.arch_init_weight_index;
    prev_valid = ifc.res_valid;
    prev_hs    = ifc.res_valid && ifc.res_ready && ifc.en;
    prev_res   = {ifc.res_index, ifc.res_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wq.delete(); wcyc.delete(); rq.delete(); hcyc.delete();
    begin_cnt = 0; done_cnt = 0; begin_cyc = -1; first_valid = -1; viol = 0;
    for (int i = 0; i < 16; i++) htab[i] = 9'($urandom);
  endtask

  task automatic start_run(input logic skip, input logic [8:0] v, output int sc);
    ifc.cfg_start = 1'b1; ifc.cfg_skip_w = skip; ifc.cfg_v = v;
    sc = cyc;
    tick();
    ifc.cfg_start = 1'b0; ifc.cfg_skip_w = 1'b0; ifc.cfg_v = 9'($urandom);
  endtask

  task automatic send_rows(input logic [26:0] rows [9], input int gaps [9]);
    for (int k = 0; k < N; k++) begin
      int n = 0;
      bit acc;
      ifc.w_valid = 1'b1; ifc.w_data = rows[k];
      do begin
        @(negedge clk);
        acc = ifc.w_ready && ifc.en;
        tick();
        n++;
      end while (!acc && n < 200);
      ifc.w_valid = 1'b0; ifc.w_data = 27'($urandom);
      repeat (gaps[k]) tick();
    end
  endtask

  task automatic read_results(input int stall_idx, input int stall_len, input int pct);
    int stalled = 0;
    int d0 = done_cnt;
    for (int n = 0; n < 1000 && done_cnt == d0; n++) begin
      if (ifc.res_valid && int'(ifc.res_index) == stall_idx && stalled < stall_len) begin
        ifc.res_ready = 1'b0;
        stalled++;
      end else ifc.res_ready = $urandom_range(99) >= pct;
      tick();
    end
    ifc.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if ({ifc.w_ready, ifc.arch_init_w_en, ifc.arch_begin_operation, ifc.res_valid, ifc.busy, ifc.done} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b want 000000", {ifc.w_ready, ifc.arch_init_w_en, ifc.arch_begin_operation, ifc.res_valid, ifc.busy, ifc.done}); end
    checks++; if (ifc.arch_init_v !== 9'h0) begin errors++; $display("FAIL reset_init_v: got %h want 0", ifc.arch_init_v); end
    checks++; if ({ifc.arch_out_index, ifc.res_index, ifc.res_data} !== 17'h0) begin errors++; $display("FAIL reset_read_side: got %h want 0", {ifc.arch_out_index, ifc.res_index, ifc.res_data}); end
    checks++; if ({ifc.arch_init_weight, ifc.arch_init_weight_index} !== 31'h0) begin errors++; $display("FAIL reset_weight_side: got %h want 0", {ifc.arch_init_weight, ifc.arch_init_weight_index}); end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if ({ifc.busy, ifc.w_ready} !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b want 00", {ifc.busy, ifc.w_ready}); end
  endtask

  task automatic test_full_run();
    logic [26:0] rows [9];
    int gaps [9];
    int sc, lw;
    clear_mon();
    for (int k = 0; k < N; k++) begin rows[k] = 27'h1002003 + 27'(k); gaps[k] = 0; end
    start_run(1'b0, 9'b101011101, sc);
    checks++; if ({ifc.busy, ifc.w_ready, ifc.arch_init_v} !== {2'b11, 9'b101011101}) begin errors++; $display("FAIL full_start: got %h want %h", {ifc.busy, ifc.w_ready, ifc.arch_init_v}, {2'b11, 9'b101011101}); end
    send_rows(rows, gaps);
    read_results(-1, 0, 0);
    checks++; if (wq.size() != N) begin errors++; $display("FAIL full_wen_count: got %0d want %0d", wq.size(), N); end
    for (int k = 0; k < N && k < wq.size(); k++) begin
      checks++; if (wq[k] !== {4'(k), rows[k]}) begin errors++; $display("FAIL full_row%0d: got %h want %h", k, wq[k], {4'(k), rows[k]}); end
    end
    lw = wcyc.size() > 0 ? wcyc[wcyc.size()-1] : -1000;
    checks++; if (begin_cnt != 1 || begin_cyc - lw != G + 1) begin errors++; $display("FAIL full_begin: got count %0d delay %0d want count 1 delay %0d", begin_cnt, begin_cyc - lw, G + 1); end
    checks++; if (first_valid - begin_cyc != R + 2) begin errors++; $display("FAIL full_run_latency: got %0d want %0d", first_valid - begin_cyc, R + 2); end
    checks++; if (rq.size() != N) begin errors++; $display("FAIL full_res_count: got %0d want %0d", rq.size(), N); end
    for (int k = 0; k < N && k < rq.size(); k++) begin
      checks++; if (rq[k] !== {4'(k), htab[k]}) begin errors++; $display("FAIL full_res%0d: got %h want %h", k, rq[k], {4'(k), htab[k]}); end
    end
    checks++; if (done_cnt != 1 || ifc.busy !== 1'b0 || viol != 0) begin errors++; $display("FAIL full_end: got done %0d busy %b viol %0d want 1 0 0", done_cnt, ifc.busy, viol); end
  endtask

  task automatic test_weight_gaps();
    logic [26:0] rows [9];
    int gaps [9];
    int sc;
    clear_mon();
    for (int k = 0; k < N; k++) begin rows[k] = 27'($urandom); gaps[k] = (k == 2 || k == 6) ? 3 : 0; end
    start_run(1'b0, 9'($urandom), sc);
    send_rows(rows, gaps);
    read_results(-1, 0, 0);
    checks++; if (wq.size() != N) begin errors++; $display("FAIL gaps_wen_count: got %0d want %0d", wq.size(), N); end
    for (int k = 0; k < N && k < wq.size(); k++) begin
      checks++; if (wq[k] !== {4'(k), rows[k]}) begin errors++; $display("FAIL gaps_row%0d: got %h want %h", k, wq[k], {4'(k), rows[k]}); end
    end
    if (wcyc.size() == N) begin
      checks++; if (wcyc[3] - wcyc[2] != 4 || wcyc[7] - wcyc[6] != 4) begin errors++; $display("FAIL gaps_spacing: got %0d,%0d want 4,4", wcyc[3] - wcyc[2], wcyc[7] - wcyc[6]); end
    end
    checks++; if (viol != 0 || done_cnt != 1 || rq.size() != N) begin errors++; $display("FAIL gaps_end: got viol %0d done %0d res %0d want 0 1 %0d", viol, done_cnt, rq.size(), N); end
  endtask

  task automatic test_backpressure();
    int sc;
    clear_mon();
    start_run(1'b1, 9'($urandom), sc);
    read_results(4, 5, 0);
    checks++; if (rq.size() != N) begin errors++; $display("FAIL bp_res_count: got %0d want %0d", rq.size(), N); end
    for (int k = 0; k < N && k < rq.size(); k++) begin
      checks++; if (rq[k] !== {4'(k), htab[k]}) begin errors++; $display("FAIL bp_res%0d: got %h want %h", k, rq[k], {4'(k), htab[k]}); end
    end
    if (hcyc.size() == N) begin
      checks++; if (hcyc[4] - hcyc[3] != 7 || hcyc[5] - hcyc[4] != 2) begin errors++; $display("FAIL bp_spacing: got %0d,%0d want 7,2", hcyc[4] - hcyc[3], hcyc[5] - hcyc[4]); end
    end
    checks++; if (viol != 0 || done_cnt != 1 || wq.size() != 0) begin errors++; $display("FAIL bp_end: got viol %0d done %0d wen %0d want 0 1 0", viol, done_cnt, wq.size()); end
  endtask

  task automatic test_enable();
    logic [26:0] rows [9];
    int gaps [9];
    int sc;
    clear_mon();
    for (int k = 0; k < N; k++) begin rows[k] = 27'($urandom); gaps[k] = 0; end
    start_run(1'b0, 9'($urandom), sc);
    fork
      send_rows(rows, gaps);
      begin
        for (int n = 0; n < 200 && wq.size() < 3; n++) tick();
        ifc.en = 1'b0; repeat (6) tick(); ifc.en = 1'b1;
      end
    join
    fork
      read_results(-1, 0, 0);
      begin
        for (int n = 0; n < 200 && begin_cnt == 0; n++) tick();
        repeat (10) tick();
        ifc.en = 1'b0; repeat (6) tick(); ifc.en = 1'b1;
      end
    join
    checks++; if (wq.size() != N) begin errors++; $display("FAIL en_wen_count: got %0d want %0d", wq.size(), N); end
    for (int k = 0; k < N && k < wq.size(); k++) begin
      checks++; if (wq[k] !== {4'(k), rows[k]}) begin errors++; $display("FAIL en_row%0d: got %h want %h", k, wq[k], {4'(k), rows[k]}); end
    end
    checks++; if (first_valid - begin_cyc != R + 2 + 6) begin errors++; $display("FAIL en_run_latency: got %0d want %0d", first_valid - begin_cyc, R + 8); end
    checks++; if (viol != 0 || begin_cnt != 1 || done_cnt != 1 || rq.size() != N) begin errors++; $display("FAIL en_end: got viol %0d begin %0d done %0d res %0d want 0 1 1 %0d", viol, begin_cnt, done_cnt, rq.size(), N); end
  endtask

  task automatic test_reset_mid_run();
    logic [26:0] rows [9];
    int gaps [9];
    int sc, b0, w0;
    logic [8:0] v;
    clear_mon();
    for (int k = 0; k < N; k++) begin rows[k] = 27'($urandom); gaps[k] = 0; end
    start_run(1'b0, 9'($urandom), sc);
    send_rows(rows, gaps);
    for (int n = 0; n < 200 && begin_cnt == 0; n++) tick();
    repeat (5) tick();
    rst = 1'b1; repeat (2) tick(); rst = 1'b0;
    checks++; if ({ifc.w_ready, ifc.arch_init_w_en, ifc.arch_begin_operation, ifc.res_valid, ifc.busy, ifc.done, ifc.arch_init_v, ifc.arch_out_index} !== 19'h0) begin errors++; $display("FAIL rstmid_outputs: got %h want 0", {ifc.w_ready, ifc.arch_init_w_en, ifc.arch_begin_operation, ifc.res_valid, ifc.busy, ifc.done, ifc.arch_init_v, ifc.arch_out_index}); end
    b0 = begin_cnt; w0 = wq.size();
    repeat (100) tick();
    checks++; if (begin_cnt != b0 || wq.size() != w0 || first_valid != -1 || ifc.busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet: got begin %0d wen %0d valid_at %0d busy %b want %0d %0d -1 0", begin_cnt, wq.size(), first_valid, ifc.busy, b0, w0); end
    clear_mon();
    v = 9'($urandom);
    start_run(1'b1, v, sc);
    checks++; if (ifc.arch_init_v !== v || ifc.w_ready !== 1'b0) begin errors++; $display("FAIL rstmid_restart: got v %h w_ready %b want %h 0", ifc.arch_init_v, ifc.w_ready, v); end
    read_results(-1, 0, 0);
    checks++; if (wq.size() != 0 || begin_cnt != 1 || begin_cyc - sc != G + 2) begin errors++; $display("FAIL rstmid_skip: got wen %0d begin %0d delay %0d want 0 1 %0d", wq.size(), begin_cnt, begin_cyc - sc, G + 2); end
    for (int k = 0; k < N && k < rq.size(); k++) begin
      checks++; if (rq[k] !== {4'(k), htab[k]}) begin errors++; $display("FAIL rstmid_res%0d: got %h want %h", k, rq[k], {4'(k), htab[k]}); end
    end
    checks++; if (rq.size() != N || done_cnt != 1) begin errors++; $display("FAIL rstmid_end: got res %0d done %0d want %0d 1", rq.size(), done_cnt, N); end
  endtask

  task automatic test_start_in_read();
    int sc;
    logic [8:0] v;
    clear_mon();
    v = 9'($urandom);
    start_run(1'b1, v, sc);
    fork
      read_results(-1, 0, 0);
      begin
        for (int n = 0; n < 300 && rq.size() < 2; n++) tick();
        ifc.cfg_start = 1'b1; ifc.cfg_skip_w = 1'b0; ifc.cfg_v = ~v;
        tick();
        ifc.cfg_start = 1'b0;
        checks++; if (ifc.busy !== 1'b1 || ifc.arch_init_v !== v || ifc.w_ready !== 1'b0) begin errors++; $display("FAIL read_start_ignored: got busy %b v %h w_ready %b want 1 %h 0", ifc.busy, ifc.arch_init_v, ifc.w_ready, v); end
      end
    join
    repeat (20) tick();
    checks++; if (done_cnt != 1 || ifc.busy !== 1'b0 || begin_cnt != 1 || wq.size() != 0) begin errors++; $display("FAIL read_start_end: got done %0d busy %b begin %0d wen %0d want 1 0 1 0", done_cnt, ifc.busy, begin_cnt, wq.size()); end
    for (int k = 0; k < N && k < rq.size(); k++) begin
      checks++; if (rq[k] !== {4'(k), htab[k]}) begin errors++; $display("FAIL read_start_res%0d: got %h want %h", k, rq[k], {4'(k), htab[k]}); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      logic [26:0] rows [9];
      int gaps [9];
      int sc;
      logic skip;
      clear_mon();
      skip = 1'($urandom);
      for (int k = 0; k < N; k++) begin rows[k] = 27'($urandom); gaps[k] = $urandom_range(2); end
      start_run(skip, 9'($urandom), sc);
      if (!skip) send_rows(rows, gaps);
      read_results(-1, 0, 30);
      checks++; if (wq.size() != (skip ? 0 : N)) begin errors++; $display("FAIL rnd%0d_wen_count: got %0d want %0d", it, wq.size(), skip ? 0 : N); end
      for (int k = 0; k < N && k < wq.size(); k++) begin
        checks++; if (wq[k] !== {4'(k), rows[k]}) begin errors++; $display("FAIL rnd%0d_row%0d: got %h want %h", it, k, wq[k], {4'(k), rows[k]}); end
      end
      checks++; if (rq.size() != N) begin errors++; $display("FAIL rnd%0d_res_count: got %0d want %0d", it, rq.size(), N); end
      for (int k = 0; k < N && k < rq.size(); k++) begin
        checks++; if (rq[k] !== {4'(k), htab[k]}) begin errors++; $display("FAIL rnd%0d_res%0d: got %h want %h", it, k, rq[k], {4'(k), htab[k]}); end
      end
      checks++; if (viol != 0 || done_cnt != 1 || begin_cnt != 1) begin errors++; $display("FAIL rnd%0d_end: got viol %0d done %0d begin %0d want 0 1 1", it, viol, done_cnt, begin_cnt); end
      repeat (3) tick();
    end
  endtask

  initial begin
    ifc.en = 1'b1; ifc.cfg_start = 1'b0; ifc.cfg_skip_w = 1'b0; ifc.cfg_v = '0;
    ifc.w_valid = 1'b0; ifc.w_data = '0; ifc.res_ready = 1'b0;
    clear_mon();
    test_reset();
    test_full_run();
    test_weight_gaps();
    test_backpressure();
    test_enable();
    test_reset_mid_run();
    test_start_in_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run by cycle %0d want finish", cyc);
    $fatal(1);
  end
endmodule

// File: doc/rbm_run_sequencer.md
Name: rbm_run_sequencer

Overview:
- Controller that owns every control input of the 9-VN/9-HN RBM test architecture: weight initialisation, visible-vector load, begin pulse, run wait and per-core result readout.
- The host side uses a start command plus valid/ready streams for weight rows in and result words out.
- Sits between the host/AXI glue and the architecture; replaces hand-driven init_weight_index / init_w_en / begin_operation / out_index sequencing.

Parameters:
- NUM_CORES, 9, number of cores; number of weight rows and result words per run.
- ROW_W, 27, weight row width (`BW_WEIGHTS * `NUM_TM_V).
- IDX_W, 4, core index width (`BW_CORE_INDEX).
- V_W, 9, visible vector width (`NUM_VN_ONECORE * `NUM_CORE_V).
- H_W, 9, hidden word width (`NUM_HN_ONECORE).
- GAP_CYCLES, 4, idle cycles between last weight write and begin pulse (min 1).
- RUN_CYCLES, 64, cycles from begin pulse to first readout (min 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  global enable; low freezes the block
- cfg_start  in  1  start command, sampled in IDLE only
- cfg_skip_w  in  1  with cfg_start: reuse loaded weights, skip LOAD_W
- cfg_v  in  V_W  visible vector, latched on accepted cfg_start
- w_valid  in  1  weight row valid
- w_data  in  ROW_W  weight row, rows sent in core order 0..NUM_CORES-1
- w_ready  out  1  weight row ready
- arch_init_weight  out  ROW_W  to architecture
- arch_init_weight_index  out  IDX_W  to architecture
- arch_init_w_en  out  1  to architecture
- arch_init_v  out  V_W  to architecture
- arch_begin_operation  out  1  to architecture, single-cycle pulse
- arch_out_index  out  IDX_W  to architecture
- arch_infer_h  in  H_W  from architecture, combinational on arch_out_index
- res_valid  out  1  result valid
- res_index  out  IDX_W  core index of res_data
- res_data  out  H_W  hidden result
- res_ready  in  1  result ready
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on leaving READ after the last word

Behaviour:
- Reset: state IDLE. All outputs 0, including arch_init_v, arch_out_index, res_*, w_ready, busy and done. Reset mid-operation aborts immediately; no further w_en or begin pulses are issued.
- en=0: state, counters and all registered outputs hold. w_ready is forced to 0. Pulses (arch_init_w_en, arch_begin_operation, done) are forced to 0 and resume when en returns. No handshakes complete while en=0.
- All outputs are registered.
- IDLE: on cfg_start, latch cfg_v into arch_init_v. Next state is ARM if cfg_skip_w=1, else LOAD_W with row counter 0.
- LOAD_W: w_ready=1. On w_valid&&w_ready, the next cycle shows:
  - arch_init_weight=w_data
  - arch_init_weight_index=row counter
  - arch_init_w_en=1 for exactly one cycle
  - Source gaps give w_en=0 cycles; the index holds its last value.
  - After accepting row NUM_CORES-1: w_ready drops the same cycle, then go to ARM.
- ARM: GAP_CYCLES cycles with w_en=0 and w_ready=0, then START.
- START: arch_begin_operation=1 for exactly one cycle, then RUN with counter RUN_CYCLES.
- RUN: decrement once per enabled cycle. At 0, go to READ with arch_out_index=0.
- READ:
  - Cycle after arch_out_index settles: capture arch_infer_h into res_data and arch_out_index into res_index; assert res_valid.
  - Hold res_* stable until res_ready. On handshake, increment arch_out_index; the next capture follows 1 cycle later.
  - After index NUM_CORES-1 handshakes: arch_out_index returns to 0, done pulses, state goes to IDLE.
- cfg_start outside IDLE is ignored. w_valid outside LOAD_W is ignored.
- Counters never wrap: the row counter saturates at NUM_CORES-1 before exit, and the index width is checked at elaboration (NUM_CORES <= 2**IDX_W).

Decomposition:
- Shared package rbm_ctrl_pkg:
  - state enum (IDLE, LOAD_W, ARM, START, RUN, READ)
  - default NUM_CORES/RUN_CYCLES/GAP_CYCLES constants derived from system_define macros
- One sub-module: seq_down_counter (load, en, dec, zero flag). It is instantiated for both the ARM gap and the RUN wait.

Test Plan:
- Full run: cfg_v=9'b101011101, rows 27'h1002003+k for k=0..8 back-to-back. Expect exactly 9 w_en pulses with index 0..8 and the matching data. Begin pulse is 1 cycle wide, GAP_CYCLES+1 cycles after the last w_en. First res_valid comes RUN_CYCLES+2 cycles after begin. Nine results arrive with index 0..8, then done.
- Weight gaps: w_valid low for 3 cycles after rows 2 and 6. Expect w_en low in those cycles, index held, all 9 rows correct, no extra pulses.
- Result backpressure: res_ready low for 5 cycles on word 4. Expect res_data/res_index stable, arch_out_index stuck at 4, no skipped or duplicated word.
- en=0 for 6 cycles during LOAD_W, then again during RUN. Expect no w_en, begin or handshake while low, and the total RUN length extended by exactly 6.
- Reset asserted mid-RUN, then cfg_start with cfg_skip_w=1. Expect all outputs 0 after reset, no begin pulse until the new run, and the new run going ARM→START with zero w_en pulses.
- cfg_start pulsed during READ. Expect it ignored, busy stays 1, and exactly one done.
